// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: access-size codes,
// FSM state encoding and wait-counter width.
package dmem_responder_pkg;

    localparam logic [2:0] SZ_W  = 3'b000;
    localparam logic [2:0] SZ_HS = 3'b001;
    localparam logic [2:0] SZ_HU = 3'b010;
    localparam logic [2:0] SZ_BS = 3'b011;
    localparam logic [2:0] SZ_BU = 3'b100;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_lane_ext.sv
// Lane selection for one access: extended load data, the byte-lane mask a
// store would touch, and whether the size/alignment combination is legal.
module dmem_lane_ext
    import dmem_responder_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  size,
    output logic [31:0] rdata,
    output logic [3:0]  lane_mask,
    output logic        legal
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    always_comb begin
        rdata     = '0;
        lane_mask = '0;
        legal     = 1'b0;
        half_sel  = addr_lo[1] ? word[31:16] : word[15:0];
        byte_sel  = word[{addr_lo, 3'b000} +: 8];
        case (size)
            SZ_W: begin
                legal     = (addr_lo == 2'b00);
                rdata     = word;
                lane_mask = 4'b1111;
            end
            SZ_HS, SZ_HU: begin
                legal     = !addr_lo[0];
                rdata     = (size == SZ_HS) ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
                lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            SZ_BS, SZ_BU: begin
                legal     = 1'b1;
                rdata     = (size == SZ_BS) ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
                lane_mask = 4'b0001 << addr_lo;
            end
            default: ;
        endcase
        // An illegal access must neither return data nor touch any lane.
        if (!legal) begin
            rdata     = '0;
            lane_mask = '0;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory responder: serialises one load/store at a time,
// inserts WAIT_CYCLES wait states and stalls the pipeline meanwhile.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

    logic [31:0]      mem [DEPTH_WORDS];
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;

    logic             lat_we;
    logic [2:0]       lat_size;
    logic [AW+1:0]    lat_addr;
    logic [31:0]      lat_wdata;

    logic             sel_we;
    logic [2:0]       sel_size;
    logic [AW+1:0]    sel_addr;
    logic [31:0]      sel_wdata;

    logic             accept, access, legal;
    logic [AW-1:0]    idx;
    logic [31:0]      rd_word, ext_rdata, wr_rep, wr_word;
    logic [3:0]       lane_mask;
    logic             addr_unused;

    assign addr_unused = ^req_addr[31:AW+2];

    assign accept = (state == ST_IDLE) && req_valid;
    assign access = (accept && (WAIT_CYCLES == 0)) || ((state == ST_WAIT) && (cnt == '0));

    // In IDLE the live request is evaluated (legality, zero-wait access);
    // afterwards only the latched copy matters.
    assign sel_we    = (state == ST_IDLE) ? req_we            : lat_we;
    assign sel_size  = (state == ST_IDLE) ? req_size          : lat_size;
    assign sel_addr  = (state == ST_IDLE) ? req_addr[AW+1:0]  : lat_addr;
    assign sel_wdata = (state == ST_IDLE) ? req_wdata         : lat_wdata;

    assign idx     = sel_addr[AW+1:2];
    assign rd_word = mem[idx];

    dmem_lane_ext u_lane_ext (
        .word      (rd_word),
        .addr_lo   (sel_addr[1:0]),
        .size      (sel_size),
        .rdata     (ext_rdata),
        .lane_mask (lane_mask),
        .legal     (legal)
    );

    always_comb begin
        wr_rep  = '0;
        wr_word = rd_word;
        case (sel_size)
            SZ_W:         wr_rep = sel_wdata;
            SZ_HS, SZ_HU: wr_rep = {2{sel_wdata[15:0]}};
            default:      wr_rep = {4{sel_wdata[7:0]}};
        endcase
        for (int i = 0; i < 4; i++) begin
            if (lane_mask[i]) wr_word[8*i +: 8] = wr_rep[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Illegal requests still walk through WAIT so error latency matches normal latency.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (req_valid) state_nxt = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (cnt == '0) state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == ST_IDLE);
        stall      = accept || (state == ST_WAIT);
        resp_valid = (state == ST_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            lat_we     <= 1'b0;
            lat_size   <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                lat_we    <= req_we;
                lat_size  <= req_size;
                lat_addr  <= req_addr[AW+1:0];
                lat_wdata <= req_wdata;
                cnt       <= CNT_LOAD;
            end else if ((state == ST_WAIT) && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (access) begin
                resp_err   <= !legal;
                resp_rdata <= (legal && !sel_we) ? ext_rdata : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && access && sel_we && legal) mem[idx] <= wr_word;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (WAIT_CYCLES 2 and 0) checked
// against a word-array reference model with directed and random requests.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid [2];
    logic        req_we    [2];
    logic [2:0]  req_size  [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        req_ready [2];
    logic        stall     [2];
    logic        resp_valid[2];
    logic [31:0] resp_rdata[2];
    logic        resp_err  [2];

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl [2][1024];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(g == 0 ? 2 : 0)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (req_valid[g]),
            .req_we     (req_we[g]),
            .req_size   (req_size[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .req_ready  (req_ready[g]),
            .stall      (stall[g]),
            .resp_valid (resp_valid[g]),
            .resp_rdata (resp_rdata[g]),
            .resp_err   (resp_err[g])
        );
    end

    function automatic int wc(int k);
        return (k == 0) ? 2 : 0;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: memory as plain words, lanes picked by shifting and masking.
    function automatic void model(int k, logic we, logic [2:0] sz, logic [31:0] a,
                                  logic [31:0] wd, output logic err, output logic [31:0] rd);
        int          w;
        int          sh;
        logic        ok;
        logic [31:0] old, mask, v;
        w   = int'(a[11:2]);
        sh  = 8 * int'(a[1:0]);
        old = mdl[k][w];
        ok  = (sz == 3'd0 && a[1:0] == 2'b00) || ((sz == 3'd1 || sz == 3'd2) && !a[0]) ||
              sz == 3'd3 || sz == 3'd4;
        err = !ok;
        rd  = '0;
        if (!ok) return;
        if (we) begin
            if (sz == 3'd0)      mask = 32'hFFFF_FFFF;
            else if (sz <= 3'd2) mask = 32'h0000_FFFF << sh;
            else                 mask = 32'h0000_00FF << sh;
            mdl[k][w] = (old & ~mask) | ((wd << sh) & mask);
        end else begin
            v = old >> sh;
            case (sz)
                3'd0: rd = old;
                3'd1: rd = v[15] ? (v | 32'hFFFF_0000) : (v & 32'h0000_FFFF);
                3'd2: rd = v & 32'h0000_FFFF;
                3'd3: rd = v[7] ? (v | 32'hFFFF_FF00) : (v & 32'h0000_00FF);
                default: rd = v & 32'h0000_00FF;
            endcase
        end
    endfunction

    task automatic xact(int k, logic we, logic [2:0] sz, logic [31:0] a, logic [31:0] wd);
        logic        exp_err;
        logic [31:0] exp_rd;
        int          n;
        bit          got;
        model(k, we, sz, a, wd, exp_err, exp_rd);
        @(negedge clk);
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_size[k]  = sz;
        req_addr[k]  = a;
        req_wdata[k] = wd;
        #1;
        chk("ready_idle", 32'(req_ready[k]), 32'd1);
        chk("stall_req", 32'(stall[k]), 32'd1);
        @(posedge clk);
        #1;
        // Inputs after acceptance must be ignored.
        req_valid[k] = 1'($urandom_range(0, 1));
        req_we[k]    = 1'($urandom);
        req_size[k]  = 3'($urandom);
        req_addr[k]  = $urandom;
        req_wdata[k] = $urandom;
        got = 0;
        for (n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (resp_valid[k]) begin
                got = 1;
                break;
            end
            chk("stall_wait", 32'(stall[k]), 32'd1);
        end
        chk("latency", 32'(n), 32'(1 + wc(k)));
        if (got) begin
            chk("resp_err", 32'(resp_err[k]), 32'(exp_err));
            chk("resp_rdata", resp_rdata[k], exp_rd);
            chk("stall_resp", 32'(stall[k]), 32'd0);
            chk("ready_resp", 32'(req_ready[k]), 32'd0);
        end
        req_valid[k] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  sz;
        logic [31:0] a;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0;
            req_we[k]    = 1'b0;
            req_size[k]  = '0;
            req_addr[k]  = '0;
            req_wdata[k] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_ready", 32'(req_ready[k]), 32'd1);
            chk("rst_stall", 32'(stall[k]), 32'd0);
            chk("rst_valid", 32'(resp_valid[k]), 32'd0);
            chk("rst_rdata", resp_rdata[k], 32'd0);
        end

        for (int k = 0; k < 2; k++) begin
            for (int w = 0; w < 16; w++) xact(k, 1'b1, SZ_W, 32'(w * 4), $urandom);
            xact(k, 1'b1, SZ_W,  32'h10, 32'hDEAD_BEEF);
            xact(k, 1'b0, SZ_W,  32'h10, 32'h0);
            xact(k, 1'b1, SZ_BS, 32'h11, 32'h0000_007F);
            xact(k, 1'b0, SZ_BS, 32'h10, 32'h0);
            xact(k, 1'b0, SZ_BU, 32'h11, 32'h0);
            xact(k, 1'b0, SZ_HS, 32'h12, 32'h0);
            xact(k, 1'b0, SZ_HU, 32'h10, 32'h0);
            xact(k, 1'b0, SZ_W,  32'h06, 32'h0);
            xact(k, 1'b1, SZ_HU, 32'h03, 32'hFFFF_FFFF);
            xact(k, 1'b0, SZ_W,  32'h00, 32'h0);
            xact(k, 1'b0, 3'b110, 32'h00, 32'h0);
            xact(k, 1'b1, 3'b101, 32'h00, 32'hA5A5_A5A5);
            xact(k, 1'b0, SZ_W,  32'h00, 32'h0);
            xact(k, 1'b1, SZ_W,  32'h1000, 32'h1234_5678);
            xact(k, 1'b0, SZ_W,  32'h0000, 32'h0);
        end

        // Reset while a store is waiting: no response, word untouched.
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_size[0]  = SZ_W;
        req_addr[0]  = 32'h20;
        req_wdata[0] = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("wait_stall", 32'(stall[0]), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rstw_ready", 32'(req_ready[0]), 32'd1);
        chk("rstw_stall", 32'(stall[0]), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rstw_novalid", 32'(resp_valid[0]), 32'd0);
        end
        xact(0, 1'b0, SZ_W, 32'h20, 32'h0);

        for (int i = 0; i < 300; i++) begin
            int k;
            k  = i % 2;
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            xact(k, 1'($urandom), sz, a, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
